// File: rtl/argmax_scheduler.sv
// Buffers one score vector from the FC stage, streams it into the argmax comparator
// one class per cycle, and delivers the class decision downstream with a timeout fallback.
module argmax_scheduler #(
  parameter int NUM_CLASS = 10,
  parameter int DW        = 12,
  parameter int TIMEOUT   = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [NUM_CLASS*DW-1:0] s_data,
  output logic                    cmp_valid,
  output logic [DW-1:0]           cmp_data,
  input  logic [3:0]              cmp_decision,
  input  logic                    cmp_valid_out,
  output logic                    d_valid,
  input  logic                    d_ready,
  output logic [3:0]              d_class,
  output logic                    busy,
  output logic [15:0]             img_count,
  output logic                    err_timeout
);

  localparam int              TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [3:0]      IDX_LAST  = 4'(NUM_CLASS - 1);
  localparam logic [TW-1:0]   TCNT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT, OUT} state_t;

  state_t                  state, state_d;
  logic [NUM_CLASS*DW-1:0] pend;
  logic                    pend_full;
  logic [DW-1:0]           work [NUM_CLASS];
  logic [3:0]              idx;
  logic [3:0]              idx_next;
  logic [TW-1:0]           tcnt;

  logic accept;
  logic load_work;
  logic step;
  logic enter_wait;
  logic take_decision;
  logic force_timeout;
  logic tcnt_inc;
  logic d_done;

  // s_ready drops while pend holds a vector, so the IDLE transfer cycle can never refill it.
  assign s_ready  = !pend_full;
  assign accept   = s_valid && s_ready;
  assign idx_next = idx + 4'd1;
  assign busy     = (state != IDLE) || pend_full;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state;
    load_work     = 1'b0;
    step          = 1'b0;
    enter_wait    = 1'b0;
    take_decision = 1'b0;
    force_timeout = 1'b0;
    tcnt_inc      = 1'b0;
    d_done        = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend_full) begin
          load_work = 1'b1;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        if (idx == IDX_LAST) begin
          enter_wait = 1'b1;
          state_d    = WAIT;
        end else begin
          step = 1'b1;
        end
      end
      WAIT: begin
        // A decision arriving on the same edge as the timeout wins over the forced result.
        if (cmp_valid_out) begin
          take_decision = 1'b1;
          state_d       = OUT;
        end else if (tcnt == TCNT_LAST) begin
          force_timeout = 1'b1;
          state_d       = OUT;
        end else begin
          tcnt_inc = 1'b1;
        end
      end
      OUT: begin
        if (d_valid && d_ready) begin
          d_done  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: vector storage carries no reset; pend_full and the FSM decide whether it is meaningful.
  always_ff @(posedge clk) begin
    if (accept) pend <= s_data;
    if (load_work) begin
      for (int i = 0; i < NUM_CLASS; i++) work[i] <= pend[i*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full   <= 1'b0;
      idx         <= 4'd0;
      tcnt        <= '0;
      cmp_valid   <= 1'b0;
      cmp_data    <= '0;
      d_valid     <= 1'b0;
      d_class     <= 4'd0;
      img_count   <= 16'd0;
      err_timeout <= 1'b0;
    end else begin
      if (accept)         pend_full <= 1'b1;
      else if (load_work) pend_full <= 1'b0;

      // Class 0 comes straight from pend so the stream starts the cycle after the transfer.
      if (load_work) begin
        idx       <= 4'd0;
        cmp_valid <= 1'b1;
        cmp_data  <= pend[DW-1:0];
      end else if (step) begin
        idx      <= idx_next;
        cmp_data <= work[idx_next];
      end else if (enter_wait) begin
        cmp_valid <= 1'b0;
        cmp_data  <= '0;
      end

      if (enter_wait)    tcnt <= '0;
      else if (tcnt_inc) tcnt <= tcnt + TW'(1);

      if (take_decision) begin
        d_valid <= 1'b1;
        d_class <= cmp_decision;
      end else if (force_timeout) begin
        d_valid     <= 1'b1;
        d_class     <= 4'hF;
        err_timeout <= 1'b1;
      end else if (d_done) begin
        d_valid   <= 1'b0;
        img_count <= img_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_argmax_scheduler.sv
// Directed bench for argmax_scheduler with a behavioural argmax comparator and a
// scoreboard of expected class decisions.
module tb_argmax_scheduler;

  localparam int NUM_CLASS = 10;
  localparam int DW        = 12;
  localparam int TIMEOUT   = 64;
  localparam int CMP_LAT   = 2;

  typedef int vec_t [NUM_CLASS];

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    s_valid = 1'b0;
  logic                    s_ready;
  logic [NUM_CLASS*DW-1:0] s_data = '0;
  logic                    cmp_valid;
  logic [DW-1:0]           cmp_data;
  logic [3:0]              cmp_decision;
  logic                    cmp_valid_out;
  logic                    d_valid;
  logic                    d_ready = 1'b1;
  logic [3:0]              d_class;
  logic                    busy;
  logic [15:0]             img_count;
  logic                    err_timeout;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] sb [$];

  always #5 clk = ~clk;

  argmax_scheduler #(.NUM_CLASS(NUM_CLASS), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .cmp_valid(cmp_valid), .cmp_data(cmp_data),
    .cmp_decision(cmp_decision), .cmp_valid_out(cmp_valid_out),
    .d_valid(d_valid), .d_ready(d_ready), .d_class(d_class),
    .busy(busy), .img_count(img_count), .err_timeout(err_timeout)
  );

  // Comparator model: strict greater-than keeps the lower index on ties.
  logic                 cmp_mute = 1'b0;
  logic                 stray_vo = 1'b0;
  logic                 m_vo;
  logic [3:0]           m_dec;
  logic [3:0]           m_cnt;
  logic [3:0]           m_best_i;
  logic signed [DW-1:0] m_best_v;
  logic                 m_armed;
  int                   m_lat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt    <= 4'd0;
      m_best_i <= 4'd0;
      m_best_v <= '0;
      m_armed  <= 1'b0;
      m_lat    <= 0;
      m_vo     <= 1'b0;
      m_dec    <= 4'd0;
    end else begin
      m_vo <= 1'b0;
      if (cmp_valid) begin
        if (m_cnt == 4'd0 || $signed(cmp_data) > m_best_v) begin
          m_best_v <= $signed(cmp_data);
          m_best_i <= m_cnt;
        end
        if (m_cnt == 4'(NUM_CLASS - 1)) begin
          m_cnt   <= 4'd0;
          m_armed <= 1'b1;
          m_lat   <= CMP_LAT;
        end else begin
          m_cnt <= m_cnt + 4'd1;
        end
      end
      if (m_armed) begin
        if (m_lat == 0) begin
          m_armed <= 1'b0;
          m_vo    <= !cmp_mute;
          m_dec   <= m_best_i;
        end else begin
          m_lat <= m_lat - 1;
        end
      end
    end
  end

  assign cmp_valid_out = m_vo | stray_vo;
  assign cmp_decision  = m_dec;

  function automatic logic [NUM_CLASS*DW-1:0] pack(input vec_t v);
    logic [NUM_CLASS*DW-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_CLASS; i++) r[i*DW +: DW] = DW'(v[i]);
    return r;
  endfunction

  function automatic logic [3:0] argmax(input vec_t v);
    int best;
    best = 0;
    for (int i = 1; i < NUM_CLASS; i++) if (v[i] > v[best]) best = i;
    return 4'(best);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " s_ready"},     32'(s_ready),     32'd1);
    check({tag, " cmp_valid"},   32'(cmp_valid),   32'd0);
    check({tag, " cmp_data"},    32'(cmp_data),    32'd0);
    check({tag, " d_valid"},     32'(d_valid),     32'd0);
    check({tag, " d_class"},     32'(d_class),     32'd0);
    check({tag, " busy"},        32'(busy),        32'd0);
    check({tag, " img_count"},   32'(img_count),   32'd0);
    check({tag, " err_timeout"}, 32'(err_timeout), 32'd0);
  endtask

  // Presents v until accepted; returns at the negedge just after the accepting edge.
  task automatic send(input vec_t v, input logic [3:0] exp);
    int n;
    n       = 0;
    s_data  = pack(v);
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("send s_ready", 32'(s_ready), 32'd1);
    sb.push_back(exp);
    tick();
    s_valid = 1'b0;
  endtask

  // Starts in the first STREAM cycle; ends in the first WAIT cycle.
  task automatic check_stream(input vec_t v, input string tag);
    logic [DW-1:0] e;
    for (int i = 0; i < NUM_CLASS; i++) begin
      e = DW'(v[i]);
      check($sformatf("%s cmp_valid[%0d]", tag, i), 32'(cmp_valid), 32'd1);
      check($sformatf("%s cmp_data[%0d]", tag, i), 32'(cmp_data), 32'(e));
      tick();
    end
    check({tag, " cmp_valid after stream"}, 32'(cmp_valid), 32'd0);
  endtask

  // Waits for d_valid and compares d_class against the oldest scoreboard entry.
  task automatic take_d(input string tag);
    int n;
    logic [3:0] exp;
    n = 0;
    while (d_valid !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check({tag, " d_valid"}, 32'(d_valid), 32'd1);
    if (d_valid === 1'b1) begin
      exp = (sb.size() > 0) ? sb.pop_front() : 4'bxxxx;
      check({tag, " d_class"}, 32'(d_class), 32'(exp));
    end
  endtask

  vec_t v1, va, vb, vc, v4, v4b, v5, vx, vy, vz;

  initial begin
    logic [3:0] exp4;
    v1  = '{5, -3, 100, 7, 0, -2048, 99, 100, 1, 2};
    va  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 2047};
    vb  = '{500, -1, -2, 499, 0, 0, 0, 0, 0, -500};
    vc  = '{9, 9, 9, 9, 9, 9, 9, 9, 9, 9};
    v4  = '{-10, -20, -30, -40, -5, -60, -70, -80, -90, -100};
    v4b = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    v5  = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
    vx  = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 100};
    vy  = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, 0};
    vz  = '{-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2047, -2048, -2048};

    // Reset state
    rst_n = 1'b0;
    tick(2);
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // Single vector with a tie at 100
    send(v1, argmax(v1));
    check("t1 s_ready after accept", 32'(s_ready), 32'd0);
    check("t1 busy", 32'(busy), 32'd1);
    check("t1 cmp_valid before stream", 32'(cmp_valid), 32'd0);
    tick();
    check_stream(v1, "t1");
    take_d("t1");
    check("t1 class is 2", 32'(d_class), 32'd2);
    tick();
    check("t1 d_valid drop", 32'(d_valid), 32'd0);
    check("t1 img_count", 32'(img_count), 32'd1);
    check("t1 busy idle", 32'(busy), 32'd0);

    // Back-to-back vectors: second accepted during the first STREAM
    send(va, argmax(va));
    tick();
    check("t2 first stream cmp_valid", 32'(cmp_valid), 32'd1);
    send(vb, argmax(vb));
    s_data  = pack(vc);
    s_valid = 1'b1;
    check("t2 third blocked", 32'(s_ready), 32'd0);
    tick();
    check("t2 third still blocked", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    take_d("t2 first");
    check("t2 first is 9", 32'(d_class), 32'd9);
    tick();
    check("t2 idle gap cmp_valid", 32'(cmp_valid), 32'd0);
    check("t2 img_count 2", 32'(img_count), 32'd2);
    check("t2 pend still full", 32'(s_ready), 32'd0);
    tick();
    check_stream(vb, "t2 second");
    take_d("t2 second");
    tick();
    check("t2 img_count 3", 32'(img_count), 32'd3);

    // Downstream stall with a vector pending behind it
    d_ready = 1'b0;
    exp4    = argmax(v4);
    send(v4, exp4);
    take_d("t3 stalled");
    send(v4b, argmax(v4b));
    for (int i = 0; i < 20; i++) begin
      check($sformatf("t3 hold d_valid %0d", i), 32'(d_valid), 32'd1);
      check($sformatf("t3 hold d_class %0d", i), 32'(d_class), 32'(exp4));
      check($sformatf("t3 hold cmp_valid %0d", i), 32'(cmp_valid), 32'd0);
      tick();
    end
    check("t3 img_count during stall", 32'(img_count), 32'd3);
    d_ready = 1'b1;
    tick();
    check("t3 d_valid after handshake", 32'(d_valid), 32'd0);
    check("t3 img_count once", 32'(img_count), 32'd4);
    take_d("t3 pending");
    tick();
    check("t3 img_count 5", 32'(img_count), 32'd5);

    // Comparator never answers
    cmp_mute = 1'b1;
    send(v5, 4'hF);
    tick(10);
    check("t4 last stream cmp_data", 32'(cmp_data), 32'(DW'(v5[9])));
    tick();
    check("t4 wait entry cmp_valid", 32'(cmp_valid), 32'd0);
    check("t4 wait entry d_valid", 32'(d_valid), 32'd0);
    tick(TIMEOUT - 1);
    check("t4 d_valid before timeout", 32'(d_valid), 32'd0);
    check("t4 err before timeout", 32'(err_timeout), 32'd0);
    tick();
    check("t4 d_valid at timeout", 32'(d_valid), 32'd1);
    check("t4 err at timeout", 32'(err_timeout), 32'd1);
    take_d("t4 timeout");
    tick();
    check("t4 img_count", 32'(img_count), 32'd6);
    cmp_mute = 1'b0;
    stray_vo = 1'b1;
    tick();
    stray_vo = 1'b0;
    tick(3);
    check("t4 stray d_valid", 32'(d_valid), 32'd0);
    check("t4 stray err sticky", 32'(err_timeout), 32'd1);
    check("t4 stray busy", 32'(busy), 32'd0);
    check("t4 stray cmp_valid", 32'(cmp_valid), 32'd0);

    // Asynchronous reset on the 5th STREAM cycle with pend full
    send(vx, argmax(vx));
    tick();
    send(vy, argmax(vy));
    tick(3);
    check("t5 5th stream cmp_data", 32'(cmp_data), 32'(DW'(vx[4])));
    check("t5 pend full", 32'(s_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("t5 async");
    sb.delete();
    tick(2);
    rst_n = 1'b1;
    tick();
    send(vz, argmax(vz));
    take_d("t5 fresh");
    check("t5 class is 7", 32'(d_class), 32'd7);
    tick();
    check("t5 img_count", 32'(img_count), 32'd1);
    check("t5 err cleared", 32'(err_timeout), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
